mips_register_file: RTL and testbench



---
 rtl/mips_register_file_if.sv | 24 ++
 rtl/mips_register_file.sv | 50 +++++
 tb/tb_mips_register_file.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mips_register_file_if.sv
// Register-file access bundle: two read-index/read-data pairs and one write port.
// The master side (decode/write-back) drives indices and write data; the slave side returns read data.
interface mips_register_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] rs;
    logic [ADDR_WIDTH-1:0] rt;
    logic [ADDR_WIDTH-1:0] rd;
    logic                  regWrite;
    logic [DATA_WIDTH-1:0] writeData;
    logic [DATA_WIDTH-1:0] readData1;
    logic [DATA_WIDTH-1:0] readData2;

    modport master (
        output rs, rt, rd, regWrite, writeData,
        input  readData1, readData2
    );

    modport slave (
        input  rs, rt, rd, regWrite, writeData,
        output readData1, readData2
    );
endinterface

// File: rtl/mips_register_file.sv
// 32-entry MIPS register file: two combinational read ports, one clocked write port, $zero hardwired.
// Define RF_BYPASS_EN to forward same-cycle write data onto matching read ports.
module mips_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mips_register_file_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] stored1;
    logic [DATA_WIDTH-1:0] stored2;

    // A write to $zero is dropped here so entry 0 keeps its reset value forever.
    assign wr_en = bus.regWrite && (bus.rd != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[bus.rd] <= bus.writeData;
        end
    end

    always_comb begin
        stored1 = '0;
        stored2 = '0;
        if (bus.rs != '0) stored1 = regs[bus.rs];
        if (bus.rt != '0) stored2 = regs[bus.rt];
    end

`ifdef RF_BYPASS_EN
    always_comb begin
        bus.readData1 = stored1;
        bus.readData2 = stored2;
        if (wr_en && (bus.rs == bus.rd)) bus.readData1 = bus.writeData;
        if (wr_en && (bus.rt == bus.rd)) bus.readData2 = bus.writeData;
    end
`else
    assign bus.readData1 = stored1;
    assign bus.readData2 = stored2;
`endif

endmodule

// File: tb/tb_mips_register_file.sv
// Scoreboard bench for mips_register_file: expected read data is queued when indices are driven
// and popped when the combinational outputs are sampled.
module tb_mips_register_file;
    localparam int DW = 32;
    localparam int AW = 5;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    logic [DW-1:0] exp1_q [$];
    logic [DW-1:0] exp2_q [$];

    mips_register_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mips_register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Drive both read indices, queue the expectation, then sample and score.
    task automatic read_chk(input string tag, input logic [AW-1:0] a, input logic [AW-1:0] b,
                            input logic [DW-1:0] e1, input logic [DW-1:0] e2);
        logic [DW-1:0] want1;
        logic [DW-1:0] want2;
        bus.rs = a;
        bus.rt = b;
        exp1_q.push_back(e1);
        exp2_q.push_back(e2);
        #1;
        want1 = exp1_q.pop_front();
        want2 = exp2_q.pop_front();
        check_val({tag, ".rd1"}, bus.readData1, want1);
        check_val({tag, ".rd2"}, bus.readData2, want2);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        bus.rd        = a;
        bus.writeData = d;
        bus.regWrite  = 1'b1;
        @(posedge clk);
        #1;
        bus.regWrite  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        bus.rs        = '0;
        bus.rt        = '0;
        bus.rd        = '0;
        bus.regWrite  = 1'b0;
        bus.writeData = '0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Populate, then assert reset mid-cycle: contents must clear without a clock edge.
        wr(5'd2, 32'hA5A5_0002);
        wr(5'd31, 32'h1234_5678);
        @(negedge clk);
        read_chk("pre_rst", 5'd2, 5'd31, 32'hA5A5_0002, 32'h1234_5678);
        #1 rst_n = 1'b0;
        read_chk("async_rst", 5'd2, 5'd31, 32'h0, 32'h0);

        // Write attempted across an edge while reset is held is blocked.
        bus.rd        = 5'd3;
        bus.writeData = 32'h0000_0077;
        bus.regWrite  = 1'b1;
        @(posedge clk);
        #1 bus.regWrite = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        read_chk("rst_wr_block", 5'd3, 5'd3, 32'h0, 32'h0);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            read_chk($sformatf("rst_sweep[%0d]", i), i[AW-1:0], 5'd0, 32'h0, 32'h0);
        end

        // Basic write then read on both ports.
        wr(5'd1, 32'd9);
        @(negedge clk);
        read_chk("basic", 5'd0, 5'd1, 32'h0, 32'd9);

        // $zero ignores writes.
        wr(5'd0, 32'hDEAD_BEEF);
        @(negedge clk);
        read_chk("zero_reg", 5'd0, 5'd0, 32'h0, 32'h0);

        // With regWrite low, held address/data must not land.
        wr(5'd5, 32'd7);
        @(negedge clk);
        bus.rd        = 5'd5;
        bus.writeData = 32'd100;
        bus.regWrite  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        read_chk("wr_disable", 5'd5, 5'd5, 32'd7, 32'd7);

        // Same-cycle read of the register being written.
        @(negedge clk);
        bus.rd        = 5'd4;
        bus.writeData = 32'd55;
        bus.regWrite  = 1'b1;
`ifdef RF_BYPASS_EN
        read_chk("bypass_pre", 5'd4, 5'd4, 32'd55, 32'd55);
`else
        read_chk("bypass_pre", 5'd4, 5'd4, 32'd0, 32'd0);
`endif
        read_chk("bypass_other", 5'd5, 5'd1, 32'd7, 32'd9);
        @(posedge clk);
        #1 bus.regWrite = 1'b0;
        @(negedge clk);
        read_chk("bypass_post", 5'd4, 5'd4, 32'd55, 32'd55);

        // Fill every register and sweep both ports in opposite directions.
        for (int i = 1; i < 32; i++) wr(i[AW-1:0], i * 3);
        for (int i = 0; i < 32; i++) begin
            logic [AW-1:0] a;
            logic [AW-1:0] b;
            a = i[AW-1:0];
            b = 5'd31 - a;
            @(negedge clk);
            read_chk($sformatf("sweep[%0d]", i), a, b, 32'(a) * 3, 32'(b) * 3);
        end

        // Overwrite keeps neighbours intact.
        wr(5'd17, 32'hCAFE_F00D);
        @(negedge clk);
        read_chk("overwrite", 5'd17, 5'd16, 32'hCAFE_F00D, 32'd48);
        read_chk("overwrite_n", 5'd18, 5'd17, 32'd54, 32'hCAFE_F00D);

        if (exp1_q.size() != 0 || exp2_q.size() != 0)
            check_val("queue_drain", 32'(exp1_q.size() + exp2_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
